fc_accum: RTL and testbench

Fully-connected MAC/accumulate stage directly downstream of the FC data register: each accepted beat multiplies the 20-element source window by a matching 20-element weight window, reduces it, and accumulates over a programmed number of windows. After the last window it adds bias, applies an arithmetic right shift, optional ReLU and signed saturation, then emits one 8-bit output neuron. One `start` produces one neuron; the FC controller sequences neurons.

---
 rtl/fc_pkg.sv | 32 +++
 rtl/fc_accum_dot20.sv | 60 ++++++
 rtl/fc_accum.sv | 128 ++++++++++++
 tb/tb_fc_accum.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared FC definitions: widths, FSM encoding,
// saturation bounds and the output clamp helper.
package fc_pkg;

  localparam int DATA_NUM     = 20;
  localparam int DATA_WIDTH   = 8;
  localparam int WEIGHT_WIDTH = 8;
  localparam int BIAS_WIDTH   = 16;
  localparam int ACC_WIDTH    = 32;
  localparam int PROD_WIDTH   = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_WIDTH    = PROD_WIDTH + 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    (2 ** (DATA_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    -(2 ** (DATA_WIDTH - 1));

  // Clamp an accumulator-width value into the output range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_data(
    input logic signed [ACC_WIDTH-1:0] v
  );
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fc_accum_dot20.sv
// Two-stage dot product: P1 registers the 20 products,
// P2 registers the adder-tree sum; a valid bit rides along.
import fc_pkg::*;

module fc_dot20 (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_i,
  input  logic [DATA_NUM*DATA_WIDTH-1:0]      src_i,
  input  logic [DATA_NUM*WEIGHT_WIDTH-1:0]    wgt_i,
  output logic                                p1_valid_o,
  output logic                                valid_o,
  output logic signed [SUM_WIDTH-1:0]         sum_o
);

  logic signed [PROD_WIDTH-1:0] prod_d [DATA_NUM];
  logic signed [PROD_WIDTH-1:0] prod_q [DATA_NUM];
  logic signed [SUM_WIDTH-1:0]  sum_d;
  logic signed [SUM_WIDTH-1:0]  sum_q;
  logic                         v1_q;
  logic                         v2_q;

  // Element-wise signed products of the current window.
  always_comb begin
    for (int i = 0; i < DATA_NUM; i++) begin
      prod_d[i] = $signed(src_i[i*DATA_WIDTH +: DATA_WIDTH])
                * $signed(wgt_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    end
  end

  // Reduce the registered products to one signed sum.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < DATA_NUM; i++) begin
      sum_d = sum_d + SUM_WIDTH'(prod_q[i]);
    end
  end

  // P1/P2 pipeline registers; data only moves on valid beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      sum_q <= '0;
      for (int i = 0; i < DATA_NUM; i++) prod_q[i] <= '0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
      if (valid_i) begin
        for (int i = 0; i < DATA_NUM; i++) prod_q[i] <= prod_d[i];
      end
      if (v1_q) sum_q <= sum_d;
    end
  end

  assign p1_valid_o = v1_q;
  assign valid_o    = v2_q;
  assign sum_o      = sum_q;

endmodule

// File: rtl/fc_accum.sv
// FC neuron accumulator: sequences windows through the dot
// pipeline, accumulates, then bias/shift/ReLU/saturate.
import fc_pkg::*;

module fc_accum (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [7:0]                        win_num,
  input  logic [BIAS_WIDTH-1:0]             bias,
  input  logic [4:0]                        shift,
  input  logic                              relu_en,
  input  logic                              win_valid,
  input  logic [DATA_NUM*DATA_WIDTH-1:0]    src_window,
  input  logic [DATA_NUM*WEIGHT_WIDTH-1:0]  weight_window,
  output logic                              busy,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data
);

  logic [1:0]                    state_q, state_d;
  logic [7:0]                    win_cnt_q, win_cnt_d;
  logic [7:0]                    win_num_q;
  logic signed [BIAS_WIDTH-1:0]  bias_q;
  logic [4:0]                    shift_q;
  logic                          relu_q;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;

  logic                          start_ok;
  logic                          accept;
  logic                          p1_valid;
  logic                          dot_valid;
  logic signed [SUM_WIDTH-1:0]   dot_sum;
  logic signed [ACC_WIDTH-1:0]   biased;
  logic signed [ACC_WIDTH-1:0]   shifted;

  // The out_valid cycle still counts as busy, so a new start
  // is only taken once that pulse has gone.
  assign busy     = (state_q != ST_IDLE) || out_valid_q;
  assign start_ok = start && !busy && (win_num != 8'd0);
  assign accept   = (state_q == ST_ACCUM) && win_valid;

  fc_dot20 u_dot (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (accept),
    .src_i      (src_window),
    .wgt_i      (weight_window),
    .p1_valid_o (p1_valid),
    .valid_o    (dot_valid),
    .sum_o      (dot_sum)
  );

  // Post-processing on the settled accumulator.
  always_comb begin
    biased  = acc_q + ACC_WIDTH'(bias_q);
    shifted = biased >>> shift_q;
    if (relu_q && shifted[ACC_WIDTH-1]) shifted = '0;
  end

  // FSM, window counter and accumulator next-state.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (dot_valid) acc_d = acc_q + ACC_WIDTH'(dot_sum);
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d   = ST_ACCUM;
          win_cnt_d = '0;
          acc_d     = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          win_cnt_d = win_cnt_q + 8'd1;
          if (win_cnt_q + 8'd1 == win_num_q) state_d = ST_DRAIN;
        end
      end
      // Once P1 is empty the last sum lands in acc this edge.
      ST_DRAIN: begin
        if (!p1_valid) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        out_valid_d = 1'b1;
        out_data_d  = sat_data(shifted);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; controls latch only on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      win_cnt_q   <= '0;
      win_num_q   <= '0;
      bias_q      <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (start_ok) begin
        win_num_q <= win_num;
        bias_q    <= bias;
        shift_q   <= shift;
        relu_q    <= relu_en;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fc_accum.sv
// Directed bench for fc_accum: a scoreboard queue holds the
// expected neuron value and cycle; a monitor pops on out_valid.
module tb_fc_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   win_num;
  logic [15:0]  bias;
  logic [4:0]   shift;
  logic         relu_en;
  logic         win_valid;
  logic [159:0] src_window;
  logic [159:0] weight_window;
  logic         busy;
  logic         out_valid;
  logic [7:0]   out_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  exp_t sb_q[$];

  fc_accum dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .win_num       (win_num),
    .bias          (bias),
    .shift         (shift),
    .relu_en       (relu_en),
    .win_valid     (win_valid),
    .src_window    (src_window),
    .weight_window (weight_window),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_data      (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input int got,
                       input int want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t e;
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_out_valid got=%0d want=none",
               $signed(out_data));
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("out_data", int'($signed(out_data)), e.data);
        check("out_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run_neuron(input int wn, input int b,
                            input int sh, input bit relu,
                            input bit rnd, input int sv,
                            input int wv, input int bubbles,
                            input bit inj);
    longint acc = 0;
    longint r;
    int lastc = 0;
    logic [7:0] sb, wb;
    exp_t e;
    @(negedge clk);
    start = 1'b1; win_num = wn[7:0]; bias = b[15:0];
    shift = sh[4:0]; relu_en = relu;
    @(negedge clk);
    start = 1'b0; win_num = 8'd9; bias = 16'h1234;
    shift = 5'd7; relu_en = ~relu;
    check("busy_after_start", int'(busy), 1);
    for (int w = 0; w < wn; w++) begin
      for (int i = 0; i < 20; i++) begin
        sb = rnd ? 8'($urandom_range(0, 255)) : sv[7:0];
        wb = rnd ? 8'($urandom_range(0, 255)) : wv[7:0];
        src_window[i*8 +: 8]    = sb;
        weight_window[i*8 +: 8] = wb;
        acc += longint'($signed(sb)) * longint'($signed(wb));
      end
      win_valid = 1'b1;
      if (inj && w == 1) begin
        start = 1'b1; win_num = 8'd1;
      end
      lastc = cyc;
      @(negedge clk);
      start = 1'b0;
      if (w != wn - 1) begin
        for (int k = 0; k < bubbles; k++) begin
          win_valid = 1'b0;
          src_window = {5{32'hDEADBEEF}};
          @(negedge clk);
        end
      end
    end
    // Stray beat during drain must be ignored.
    src_window = {5{32'h7F7F7F7F}};
    weight_window = {5{32'h7F7F7F7F}};
    win_valid = 1'b1;
    r = (acc + longint'(b)) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    e.data = int'(r);
    e.cyc  = lastc + 4;
    sb_q.push_back(e);
    @(negedge clk);
    win_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("neuron_done", int'(out_valid), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; win_num = '0; bias = '0;
    shift = '0; relu_en = 1'b0; win_valid = 1'b0;
    src_window = '0; weight_window = '0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    rst = 1'b0;

    run_neuron(1, 0, 0, 1'b0, 1'b0, 1, 2, 0, 1'b0);
    run_neuron(3, 5, 2, 1'b0, 1'b0, 10, -1, 0, 1'b0);
    run_neuron(3, 5, 2, 1'b1, 1'b0, 10, -1, 0, 1'b0);
    run_neuron(2, 0, 8, 1'b0, 1'b0, 127, 127, 3, 1'b0);
    run_neuron(3, -300, 0, 1'b0, 1'b0, 1, 1, 2, 1'b1);

    // win_num == 0 is ignored.
    @(negedge clk);
    start = 1'b1; win_num = 8'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("zero_win_busy", int'(busy), 0);
      @(negedge clk);
    end

    // Abort mid-neuron with reset.
    start = 1'b1; win_num = 8'd4; bias = 16'd0; shift = 5'd0;
    @(negedge clk);
    start = 1'b0;
    src_window = {20{8'd5}}; weight_window = {20{8'd5}};
    win_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    win_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);

    run_neuron(1, -60, 0, 1'b1, 1'b0, 3, 1, 0, 1'b0);
    run_neuron(1, -60, 0, 1'b0, 1'b0, 3, 1, 0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      run_neuron(3, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(10, 13)),
                 1'($urandom_range(0, 1)), 1'b1, 0, 0,
                 n, 1'b0);
    end

    // Output holds after the pulse.
    @(negedge clk); @(negedge clk);
    check("hold_out_valid", int'(out_valid), 0);
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
